// File: rtl/ifu_fetch.sv
// Instruction fetch unit: issues one word fetch at a time, buffers the
// returned instruction for decode and handles redirects from execute by
// squashing any in-flight or buffered instruction from the old path.
//
// state | meaning
// REQ   | presenting a fetch request at pc, waiting for memory to accept
// WAIT  | request accepted, waiting for the response (drop=1 squashes it)
// HOLD  | instruction buffered and offered to decode
module ifu_fetch #(
  parameter logic [31:0] RESET_PC = 32'h80000000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic [31:0] mem_req_addr,
  input  logic        mem_rsp_valid,
  input  logic [31:0] mem_rsp_data,
  input  logic        mem_rsp_err,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  output logic        inst_err,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic [31:0] fetch_cnt
);

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2
  } state_t;

  state_t      state;
  logic [31:0] pc;
  logic        drop;
  logic [31:0] redir_pc_al;

  // Redirect targets are word aligned by discarding the low two bits.
  assign redir_pc_al = {redirect_pc[31:2], 2'b00};

  // Handshake outputs are pure decodes of the state register.
  assign mem_req_valid = (state == S_REQ);
  assign mem_req_addr  = pc;
  assign inst_valid    = (state == S_HOLD);

  // Fetch sequencer: request, await response, hold for decode.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= S_REQ;
      pc        <= {RESET_PC[31:2], 2'b00};
      drop      <= 1'b0;
      inst      <= 32'h0;
      inst_pc   <= 32'h0;
      inst_err  <= 1'b0;
      fetch_cnt <= 32'h0;
    end else begin
      case (state)
        S_REQ: begin
          if (mem_req_ready) state <= S_WAIT;
          if (redirect_valid) begin
            pc <= redir_pc_al;
            // The old-address request still goes out; squash its response.
            if (mem_req_ready) drop <= 1'b1;
          end
        end
        S_WAIT: begin
          if (mem_rsp_valid) begin
            if (drop || redirect_valid) begin
              drop  <= 1'b0;
              state <= S_REQ;
              if (redirect_valid) pc <= redir_pc_al;
            end else begin
              inst     <= mem_rsp_data;
              inst_pc  <= pc;
              inst_err <= mem_rsp_err;
              pc       <= pc + 32'd4;
              state    <= S_HOLD;
            end
          end else if (redirect_valid) begin
            pc   <= redir_pc_al;
            drop <= 1'b1;
          end
        end
        S_HOLD: begin
          if (redirect_valid) begin
            // Buffered instruction is on the wrong path: discard uncounted.
            pc    <= redir_pc_al;
            state <= S_REQ;
          end else if (inst_ready) begin
            fetch_cnt <= fetch_cnt + 32'd1;
            state     <= S_REQ;
          end
        end
        default: state <= S_REQ;
      endcase
    end
  end

endmodule

// File: tb/tb_ifu_fetch.sv
// Directed bench for ifu_fetch: inputs change on the falling edge, outputs
// are checked on the falling edge, expected values are hand computed.
module tb_ifu_fetch;

  logic        clk = 1'b0;
  logic        reset;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic [31:0] mem_req_addr;
  logic        mem_rsp_valid;
  logic [31:0] mem_rsp_data;
  logic        mem_rsp_err;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        inst_err;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [31:0] fetch_cnt;

  int checks = 0;
  int failures = 0;

  ifu_fetch #(.RESET_PC(32'h80000000)) dut (
    .clk(clk), .reset(reset),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_req_addr(mem_req_addr),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data),
    .mem_rsp_err(mem_rsp_err),
    .inst_valid(inst_valid), .inst_ready(inst_ready),
    .inst(inst), .inst_pc(inst_pc), .inst_err(inst_err),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .fetch_cnt(fetch_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // From REQ: accept request, return one response; ends in HOLD.
  task automatic fetch(input logic [31:0] data, input logic err);
    mem_req_ready = 1'b1;
    step();
    mem_req_ready = 1'b0;
    mem_rsp_valid = 1'b1;
    mem_rsp_data  = data;
    mem_rsp_err   = err;
    step();
    mem_rsp_valid = 1'b0;
    mem_rsp_err   = 1'b0;
  endtask

  task automatic deliver();
    inst_ready = 1'b1;
    step();
    inst_ready = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    mem_req_ready = 0; mem_rsp_valid = 0; mem_rsp_data = 0; mem_rsp_err = 0;
    inst_ready = 0; redirect_valid = 0; redirect_pc = 0;
    #3 reset = 1'b0;
    #1;
    chk("rst_req_valid", {31'b0, mem_req_valid}, 32'd1);
    chk("rst_req_addr", mem_req_addr, 32'h80000000);
    chk("rst_inst_valid", {31'b0, inst_valid}, 32'd0);
    chk("rst_cnt", fetch_cnt, 32'd0);
    chk("rst_inst", inst, 32'd0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;

    // Basic fetch with 2-cycle latency
    chk("t1_req_valid", {31'b0, mem_req_valid}, 32'd1);
    chk("t1_req_addr", mem_req_addr, 32'h80000000);
    mem_req_ready = 1'b1;
    step();
    mem_req_ready = 1'b0;
    chk("t1_wait_req", {31'b0, mem_req_valid}, 32'd0);
    chk("t1_wait_iv", {31'b0, inst_valid}, 32'd0);
    mem_rsp_valid = 1'b1; mem_rsp_data = 32'h00100093;
    step();
    mem_rsp_valid = 1'b0;
    chk("t1_iv", {31'b0, inst_valid}, 32'd1);
    chk("t1_inst", inst, 32'h00100093);
    chk("t1_pc", inst_pc, 32'h80000000);
    chk("t1_err", {31'b0, inst_err}, 32'd0);
    deliver();
    chk("t1_iv_after", {31'b0, inst_valid}, 32'd0);
    chk("t1_next_addr", mem_req_addr, 32'h80000004);
    chk("t1_cnt", fetch_cnt, 32'd1);

    // HOLD stall with stray responses
    fetch(32'h0000AAAA, 1'b0);
    for (int i = 0; i < 5; i++) begin
      chk("t2_iv", {31'b0, inst_valid}, 32'd1);
      chk("t2_inst", inst, 32'h0000AAAA);
      chk("t2_pc", inst_pc, 32'h80000004);
      chk("t2_req", {31'b0, mem_req_valid}, 32'd0);
      chk("t2_cnt", fetch_cnt, 32'd1);
      mem_rsp_valid = 1'b1; mem_rsp_data = 32'hFFFF0000 + i;
      step();
    end
    mem_rsp_valid = 1'b0;
    chk("t2_inst_end", inst, 32'h0000AAAA);
    deliver();
    chk("t2_cnt_end", fetch_cnt, 32'd2);
    chk("t2_addr", mem_req_addr, 32'h80000008);

    // Request stays pending while memory is not ready
    step();
    step();
    chk("t3_req_hold", {31'b0, mem_req_valid}, 32'd1);
    chk("t3_addr_hold", mem_req_addr, 32'h80000008);

    // Access fault
    fetch(32'h12345678, 1'b1);
    chk("t3_err", {31'b0, inst_err}, 32'd1);
    chk("t3_pc", inst_pc, 32'h80000008);
    deliver();
    chk("t3_next", mem_req_addr, 32'h8000000C);
    chk("t3_cnt", fetch_cnt, 32'd3);

    // Redirect in WAIT, response arrives later
    mem_req_ready = 1'b1;
    step();
    mem_req_ready = 1'b0;
    redirect_valid = 1'b1; redirect_pc = 32'h80000103;
    step();
    redirect_valid = 1'b0;
    chk("t4_still_wait", {31'b0, mem_req_valid}, 32'd0);
    mem_rsp_valid = 1'b1; mem_rsp_data = 32'hDEADDEAD;
    step();
    mem_rsp_valid = 1'b0;
    chk("t4_dropped", {31'b0, inst_valid}, 32'd0);
    chk("t4_addr", mem_req_addr, 32'h80000100);
    fetch(32'h00000011, 1'b0);
    chk("t4_pc", inst_pc, 32'h80000100);
    chk("t4_inst", inst, 32'h00000011);
    deliver();
    chk("t4_cnt", fetch_cnt, 32'd4);
    chk("t4_next", mem_req_addr, 32'h80000104);

    // Redirect coincident with response in WAIT
    mem_req_ready = 1'b1;
    step();
    mem_req_ready = 1'b0;
    mem_rsp_valid = 1'b1; mem_rsp_data = 32'hBAD00001;
    redirect_valid = 1'b1; redirect_pc = 32'h80000200;
    step();
    mem_rsp_valid = 1'b0; redirect_valid = 1'b0;
    chk("t5_dropped", {31'b0, inst_valid}, 32'd0);
    chk("t5_addr", mem_req_addr, 32'h80000200);
    fetch(32'h00000022, 1'b0);
    chk("t5_pc", inst_pc, 32'h80000200);
    deliver();
    chk("t5_cnt", fetch_cnt, 32'd5);

    // Redirect coincident with request acceptance in REQ
    mem_req_ready = 1'b1;
    redirect_valid = 1'b1; redirect_pc = 32'h80000300;
    step();
    mem_req_ready = 1'b0; redirect_valid = 1'b0;
    chk("t6_wait", {31'b0, mem_req_valid}, 32'd0);
    mem_rsp_valid = 1'b1; mem_rsp_data = 32'hBAD00002;
    step();
    mem_rsp_valid = 1'b0;
    chk("t6_dropped", {31'b0, inst_valid}, 32'd0);
    chk("t6_addr", mem_req_addr, 32'h80000300);
    fetch(32'h00000033, 1'b0);
    chk("t6_pc", inst_pc, 32'h80000300);
    chk("t6_inst", inst, 32'h00000033);
    deliver();
    chk("t6_cnt", fetch_cnt, 32'd6);

    // Redirect in REQ without acceptance
    redirect_valid = 1'b1; redirect_pc = 32'h80000400;
    step();
    redirect_valid = 1'b0;
    chk("t7_req", {31'b0, mem_req_valid}, 32'd1);
    chk("t7_addr", mem_req_addr, 32'h80000400);
    fetch(32'h00000044, 1'b0);
    chk("t7_iv", {31'b0, inst_valid}, 32'd1);
    chk("t7_pc", inst_pc, 32'h80000400);
    deliver();
    chk("t7_cnt", fetch_cnt, 32'd7);

    // Redirect in HOLD with inst_ready: not counted
    fetch(32'h00000055, 1'b0);
    inst_ready = 1'b1;
    redirect_valid = 1'b1; redirect_pc = 32'h80000500;
    step();
    inst_ready = 1'b0; redirect_valid = 1'b0;
    chk("t8_iv", {31'b0, inst_valid}, 32'd0);
    chk("t8_cnt", fetch_cnt, 32'd7);
    chk("t8_addr", mem_req_addr, 32'h80000500);

    // Counter wrap
    fetch(32'h00000066, 1'b0);
    force dut.fetch_cnt = 32'hFFFFFFFF;
    #1;
    release dut.fetch_cnt;
    #1;
    chk("t9_preload", fetch_cnt, 32'hFFFFFFFF);
    @(negedge clk);
    deliver();
    chk("t9_wrap", fetch_cnt, 32'd0);
    chk("t9_addr", mem_req_addr, 32'h80000504);

    // Reset mid-WAIT, late response ignored
    mem_req_ready = 1'b1;
    step();
    mem_req_ready = 1'b0;
    #2 reset = 1'b0;
    #1;
    chk("t10_rst_req", {31'b0, mem_req_valid}, 32'd1);
    chk("t10_rst_addr", mem_req_addr, 32'h80000000);
    chk("t10_rst_inst", inst, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    mem_rsp_valid = 1'b1; mem_rsp_data = 32'hBAD00003;
    step();
    mem_rsp_valid = 1'b0;
    chk("t10_iv", {31'b0, inst_valid}, 32'd0);
    chk("t10_req", {31'b0, mem_req_valid}, 32'd1);
    chk("t10_addr", mem_req_addr, 32'h80000000);
    chk("t10_cnt", fetch_cnt, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
